// File: rtl/palette_pkg.sv
// Shared palette definitions: index/distance widths, the 16-entry colour table, encoder FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package palette_pkg;

  localparam int PAL_IDX_W = 4;
  localparam int DIST_W    = 10;
  localparam int PAL_N     = 16;

  // Entry 15 sits in the most significant slot, so PALETTE[i] is entry i.
  // The same table drives color_mapper, so edit both directions together.
  localparam logic [PAL_N-1:0][23:0] PALETTE = {
    24'hf200ff,  // 15
    24'h000000,  // 14
    24'h00710e,  // 13
    24'haaaaaa,  // 12
    24'haaaaaa,  // 11
    24'haaaaaa,  // 10
    24'haaaaaa,  // 9
    24'haaaaaa,  // 8
    24'h242424,  // 7
    24'hff5252,  // 6
    24'hcf1010,  // 5
    24'h00bbd4,  // 4
    24'h2195f3,  // 3
    24'h3b3b3b,  // 2
    24'h0e0e0e,  // 1
    24'hffffff   // 0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/rgb_l1_dist.sv
// L1 distance |dR|+|dG|+|dB| between two 24-bit RGB colours.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module rgb_l1_dist
  import palette_pkg::*;
(
  input  logic [23:0]       i_a,
  input  logic [23:0]       i_b,
  output logic [DIST_W-1:0] o_dist
);

  logic [7:0] w_dr;
  logic [7:0] w_dg;
  logic [7:0] w_db;

  // Per-channel absolute difference in 8 bits, then a 10-bit sum (max 765, no overflow).
  always_comb begin
    w_dr   = (i_a[23:16] >= i_b[23:16]) ? (i_a[23:16] - i_b[23:16]) : (i_b[23:16] - i_a[23:16]);
    w_dg   = (i_a[15:8]  >= i_b[15:8])  ? (i_a[15:8]  - i_b[15:8])  : (i_b[15:8]  - i_a[15:8]);
    w_db   = (i_a[7:0]   >= i_b[7:0])   ? (i_a[7:0]   - i_b[7:0])   : (i_b[7:0]   - i_a[7:0]);
    o_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};
  end

endmodule

// File: rtl/palette_encoder.sv
// Maps an RGB pixel to the nearest (L1) palette index by scanning one entry per cycle.
// Latency: result valid 16 edges after accept (EARLY_EXIT: 1+i edges for first exact hit at i).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module palette_encoder
  import palette_pkg::*;
#(
  parameter int EARLY_EXIT = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_R,
  input  logic [7:0]           in_G,
  input  logic [7:0]           in_B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAL_IDX_W-1:0] color_pallete_enum,
  output logic [DIST_W-1:0]    out_dist,
  output logic                 out_exact
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PAL_IDX_W-1:0] r_idx;
  logic [23:0]          r_pix;
  logic [DIST_W-1:0]    r_best_dist;
  logic [PAL_IDX_W-1:0] r_best_idx;
  logic [PAL_IDX_W-1:0] r_enum;
  logic [DIST_W-1:0]    r_dist;
  logic                 r_exact;

  logic [DIST_W-1:0]    w_d;
  logic [DIST_W-1:0]    w_cand_dist;
  logic [PAL_IDX_W-1:0] w_cand_idx;
  logic                 w_accept;
  logic                 w_last;

  rgb_l1_dist u_dist (
    .i_a    (r_pix),
    .i_b    (PALETTE[r_idx]),
    .o_dist (w_d)
  );

  // Candidate best including the current entry; strict less-than keeps the lower index on ties.
  always_comb begin
    w_cand_dist = r_best_dist;
    w_cand_idx  = r_best_idx;
    if (w_d < r_best_dist) begin
      w_cand_dist = w_d;
      w_cand_idx  = r_idx;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = (r_state == IDLE);
    out_valid   = (r_state == DONE);
    w_accept    = in_valid && (r_state == IDLE);
    w_last      = (r_idx == 4'hF) || ((EARLY_EXIT != 0) && (w_d == '0));
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = SEARCH;
      SEARCH:  if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any search in flight.
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Search datapath: latch pixel on accept, track running best, load outputs on the final entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_idx       <= '0;
      r_pix       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_enum      <= '0;
      r_dist      <= '0;
      r_exact     <= 1'b0;
    end else if (w_accept) begin
      r_pix       <= {in_R, in_G, in_B};
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_idx       <= '0;
    end else if (r_state == SEARCH) begin
      r_best_dist <= w_cand_dist;
      r_best_idx  <= w_cand_idx;
      if (w_last) begin
        r_enum  <= w_cand_idx;
        r_dist  <= w_cand_dist;
        r_exact <= (w_cand_dist == '0);
      end else begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign color_pallete_enum = r_enum;
  assign out_dist           = r_dist;
  assign out_exact          = r_exact;

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder with one EARLY_EXIT=0 and one EARLY_EXIT=1 instance.
// Latency: measured in edges from the accept edge to the first cycle out_valid is seen.
// Backpressure: exercised by holding out_ready low in DONE.
module tb_palette_encoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       out_ready;
  logic [7:0] in_R, in_G, in_B;
  logic       in_valid0, in_valid1;

  logic       in_ready0, out_valid0, out_exact0;
  logic [3:0] enum0;
  logic [9:0] dist0;
  logic       in_ready1, out_valid1, out_exact1;
  logic [3:0] enum1;
  logic [9:0] dist1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  palette_encoder #(.EARLY_EXIT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .out_valid(out_valid0), .out_ready(out_ready),
    .color_pallete_enum(enum0), .out_dist(dist0), .out_exact(out_exact0)
  );

  palette_encoder #(.EARLY_EXIT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .out_valid(out_valid1), .out_ready(out_ready),
    .color_pallete_enum(enum1), .out_dist(dist1), .out_exact(out_exact1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the selected instance idle and out_ready high.
  task automatic run_pixel(input bit sel, input logic [7:0] r, input logic [7:0] g,
                           input logic [7:0] b, input logic [3:0] e_idx,
                           input logic [9:0] e_dist, input int e_lat, input string tag);
    int  cnt;
    logic seen;
    in_R = r; in_G = g; in_B = b;
    if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
    cnt  = 0;
    seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(negedge Clk);
      cnt++;
      if (cnt == 1) begin
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
      end
      seen = sel ? out_valid1 : out_valid0;
    end
    chk({tag, "_valid"}, 32'(seen), 32'd1);
    chk({tag, "_lat"},   32'(cnt - 1), 32'(e_lat));
    chk({tag, "_enum"},  32'(sel ? enum1 : enum0), 32'(e_idx));
    chk({tag, "_dist"},  32'(sel ? dist1 : dist0), 32'(e_dist));
    chk({tag, "_exact"}, 32'(sel ? out_exact1 : out_exact0), 32'(e_dist == 10'd0));
    @(negedge Clk);
    chk({tag, "_idle"},  32'(sel ? in_ready1 : in_ready0), 32'd1);
  endtask

  initial begin : stim
    int  cnt;
    logic seen;

    Reset = 1'b1; out_ready = 1'b1; in_valid0 = 1'b0; in_valid1 = 1'b0;
    in_R = 8'h00; in_G = 8'h00; in_B = 8'h00;
    repeat (3) @(negedge Clk);
    chk("rst_in_ready",  32'(in_ready0),  32'd1);
    chk("rst_out_valid", 32'(out_valid0), 32'd0);
    chk("rst_enum",      32'(enum0),      32'd0);
    chk("rst_dist",      32'(dist0),      32'd0);
    chk("rst_exact",     32'(out_exact0), 32'd0);
    chk("rst_in_ready1", 32'(in_ready1),  32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_in_ready", 32'(in_ready0), 32'd1);

    // Exact white: full scan vs early exit at index 0; early exit at first of the aa duplicates.
    run_pixel(1'b0, 8'hff, 8'hff, 8'hff, 4'd0,  10'd0,  16, "white_ee0");
    run_pixel(1'b1, 8'hff, 8'hff, 8'hff, 4'd0,  10'd0,  1,  "white_ee1");
    run_pixel(1'b1, 8'haa, 8'haa, 8'haa, 4'd8,  10'd0,  9,  "grey_ee1");

    // Tie break and nearest non-exact.
    run_pixel(1'b0, 8'haa, 8'haa, 8'haa, 4'd8,  10'd0,  16, "grey_tie");
    run_pixel(1'b0, 8'h0c, 8'h0c, 8'h0c, 4'd1,  10'd6,  16, "dark_0c");
    run_pixel(1'b0, 8'hff, 8'h00, 8'h00, 4'd5,  10'd80, 16, "red");
    run_pixel(1'b0, 8'h00, 8'h00, 8'h00, 4'd14, 10'd0,  16, "black");

    // Backpressure in DONE with a second pixel already waiting on the input.
    out_ready = 1'b0;
    in_R = 8'h00; in_G = 8'h00; in_B = 8'h00; in_valid0 = 1'b1;
    @(negedge Clk);
    in_R = 8'hff; in_G = 8'h00; in_B = 8'h00;
    cnt = 1; seen = out_valid0;
    while (cnt < 40 && !seen) begin
      @(negedge Clk);
      cnt++;
      seen = out_valid0;
    end
    chk("bp_valid", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk("bp_hold_valid", 32'(out_valid0), 32'd1);
      chk("bp_hold_enum",  32'(enum0),      32'd14);
      chk("bp_hold_dist",  32'(dist0),      32'd0);
      chk("bp_hold_exact", 32'(out_exact0), 32'd1);
      chk("bp_hold_ready", 32'(in_ready0),  32'd0);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    chk("bp_rel_valid",  32'(out_valid0), 32'd0);
    chk("bp_rel_ready",  32'(in_ready0),  32'd1);
    chk("bp_rel_retain", 32'(enum0),      32'd14);
    @(negedge Clk);
    chk("b2b_accepted", 32'(in_ready0), 32'd0);
    in_valid0 = 1'b0;
    cnt = 1; seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(negedge Clk);
      cnt++;
      seen = out_valid0;
    end
    chk("b2b_valid", 32'(seen), 32'd1);
    chk("b2b_lat",   32'(cnt - 1), 32'd16);
    chk("b2b_enum",  32'(enum0), 32'd5);
    chk("b2b_dist",  32'(dist0), 32'd80);
    @(negedge Clk);

    // Reset while the search is evaluating entry 7.
    in_R = 8'h00; in_G = 8'h00; in_B = 8'h00; in_valid0 = 1'b1;
    @(negedge Clk);
    in_valid0 = 1'b0;
    repeat (7) @(negedge Clk);
    chk("mid_busy", 32'(in_ready0), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_valid", 32'(out_valid0), 32'd0);
    chk("mid_rst_enum",  32'(enum0),      32'd0);
    chk("mid_rst_dist",  32'(dist0),      32'd0);
    chk("mid_rst_ready", 32'(in_ready0),  32'd1);
    Reset = 1'b0;
    run_pixel(1'b0, 8'h00, 8'h71, 8'h0e, 4'd13, 10'd0, 16, "green");

    // Input wiggles while searching; only the latched pixel counts, held pixel waits for IDLE.
    in_R = 8'h0c; in_G = 8'h0c; in_B = 8'h0c; in_valid0 = 1'b1;
    cnt = 0; seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(negedge Clk);
      cnt++;
      in_R = 8'(cnt * 37); in_G = 8'(cnt * 91); in_B = 8'(255 - cnt * 13);
      seen = out_valid0;
    end
    chk("hold_valid", 32'(seen), 32'd1);
    chk("hold_lat",   32'(cnt - 1), 32'd16);
    chk("hold_enum",  32'(enum0), 32'd1);
    chk("hold_dist",  32'(dist0), 32'd6);
    chk("hold_exact", 32'(out_exact0), 32'd0);
    in_R = 8'h3c; in_G = 8'h3b; in_B = 8'h3b;
    @(negedge Clk);
    chk("hold_idle_ready", 32'(in_ready0),  32'd1);
    chk("hold_idle_valid", 32'(out_valid0), 32'd0);
    @(negedge Clk);
    chk("hold_second_acc", 32'(in_ready0), 32'd0);
    in_valid0 = 1'b0;
    cnt = 1; seen = 1'b0;
    while (cnt < 40 && !seen) begin
      @(negedge Clk);
      cnt++;
      seen = out_valid0;
    end
    chk("second_valid", 32'(seen), 32'd1);
    chk("second_enum",  32'(enum0), 32'd2);
    chk("second_dist",  32'(dist0), 32'd1);
    chk("second_exact", 32'(out_exact0), 32'd0);
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
